control_seq: RTL



---
 rtl/control_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/control_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | control_seq : multi-cycle 8080-subset sequencer (FETCH/EXEC/HALT FSM).   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module control_seq #(
  parameter logic [2:0] ACC_CODE = 3'b111,
  parameter logic [2:0] MEM_CODE = 3'b110,
  parameter bit         IMM_EN   = 1'b1,
  parameter int         WAIT_MAX = 0,
  parameter int         TO_W     = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] ir_data,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       ir_load,
  output logic       data_in_select,
  output logic [7:0] reg_select,
  output logic [7:0] reg_enable,
  output logic       r1_enable,
  output logic       r2_enable,
  output logic       r2_select,
  output logic [2:0] alu_op,
  output logic       flags_enable,
  output logic       done,
  output logic       illegal,
  output logic       timeout,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam bit            TO_EN   = (WAIT_MAX > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  state_t          state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [7:0]      reg_sel_raw;

  function automatic logic [7:0] onehot(input logic [2:0] code);
    return 8'(1) << code;
  endfunction

  logic [2:0] ddd, sss;
  logic       is_hlt, is_mov, is_mvi, is_alur, is_alui, is_legal, to_hit;

  assign ddd     = ir_data[5:3];
  assign sss     = ir_data[2:0];
  assign is_hlt  = (ir_data == 8'h76);
  assign is_mov  = (ir_data[7:6] == 2'b01) && !is_hlt;
  assign is_mvi  = (ir_data[7:6] == 2'b00) && (sss == 3'b110);
  assign is_alur = (ir_data[7:6] == 2'b10);
  assign is_alui = IMM_EN && (ir_data[7:6] == 2'b11) && (sss == 3'b110);
  assign is_legal = is_hlt
                  | (is_mov && (ddd != MEM_CODE) && (sss != MEM_CODE))
                  | (is_mvi && (ddd != MEM_CODE))
                  | (is_alur && (sss != MEM_CODE))
                  | is_alui;
  // Counter is only meaningful inside a wait step; it sits at zero elsewhere.
  assign to_hit  = TO_EN && (cnt_q == TO_LAST) && !din_valid;

  assign reg_select = reg_sel_raw & ~onehot(MEM_CODE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    cnt_d          = '0;
    din_ready      = 1'b0;
    ir_load        = 1'b0;
    data_in_select = 1'b0;
    reg_sel_raw    = 8'h00;
    reg_enable     = 8'h00;
    r1_enable      = 1'b0;
    r2_enable      = 1'b0;
    r2_select      = 1'b0;
    alu_op         = 3'd0;
    flags_enable   = 1'b0;
    done           = 1'b0;
    illegal        = 1'b0;
    timeout        = 1'b0;
    busy           = 1'b0;
    halted         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_load = 1'b1;
        busy    = 1'b1;
        state_d = S_EXEC;
        step_d  = 2'd0;
      end
      default: begin
        busy = 1'b1;
        if (is_hlt) begin
          done    = 1'b1;
          state_d = S_HALT;
        end else if (!is_legal) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else if (is_mov) begin
          reg_sel_raw = onehot(sss);
          reg_enable  = onehot(ddd);
          done        = 1'b1;
          state_d     = S_FETCH;
        end else if (is_mvi) begin
          din_ready      = 1'b1;
          data_in_select = 1'b1;
          if (din_valid) begin
            reg_enable = onehot(ddd);
            done       = 1'b1;
            state_d    = S_FETCH;
          end else if (to_hit) begin
            timeout = 1'b1;
            state_d = S_FETCH;
          end else if (TO_EN) begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end else begin
          case (step_q)
            2'd0: begin
              reg_sel_raw = onehot(ACC_CODE);
              r1_enable   = 1'b1;
              step_d      = 2'd1;
            end
            2'd1: begin
              alu_op = ddd;
              if (is_alui) begin
                din_ready      = 1'b1;
                data_in_select = 1'b1;
                r2_enable      = din_valid;
                if (din_valid) begin
                  step_d = 2'd2;
                end else if (to_hit) begin
                  timeout = 1'b1;
                  state_d = S_FETCH;
                end else if (TO_EN) begin
                  cnt_d = cnt_q + TO_W'(1);
                end
              end else begin
                reg_sel_raw = onehot(sss);
                r2_enable   = 1'b1;
                step_d      = 2'd2;
              end
            end
            default: begin
              r2_select    = 1'b1;
              alu_op       = ddd;
              flags_enable = 1'b1;
              // CMP only updates flags.
              if (ddd != 3'b111) reg_enable = onehot(ACC_CODE);
              done         = 1'b1;
              state_d      = S_FETCH;
            end
          endcase
        end
      end
    endcase
  end

endmodule
`default_nettype wire
